// File: rtl/pwm_carrier_gen_pkg.sv
// Shared types and widths for the PWM carrier generator and its prescaler.
package pwm_carrier_gen_pkg;

    localparam int PWMCOUNT_WIDTH = 16;
    localparam int DIVCLK_WIDTH   = 4;
    localparam int EVTCOUNT_WIDTH = 3;

    typedef enum logic [1:0] {
        NO_COUNT     = 2'd0,
        COUNT_UP     = 2'd1,
        COUNT_DOWN   = 2'd2,
        COUNT_UPDOWN = 2'd3
    } count_mode_e;

    typedef enum logic [1:0] {
        NO_MASK     = 2'd0,
        MIN_MASK    = 2'd1,
        MAX_MASK    = 2'd2,
        MINMAX_MASK = 2'd3
    } mask_mode_e;

    typedef enum logic {CARR_OFF   = 1'b0, CARR_ON   = 1'b1} carr_onoff_e;
    typedef enum logic {CLKDIV_OFF = 1'b0, CLKDIV_ON = 1'b1} clkdiv_onoff_e;
    typedef enum logic {INT_OFF    = 1'b0, INT_ON    = 1'b1} int_onoff_e;

    // A coincident min+max pulse is a single event.
    function automatic logic evt_selected(input mask_mode_e mask, input logic min_evt,
                                          input logic max_evt);
        logic sel;
        case (mask)
            MIN_MASK:    sel = min_evt;
            MAX_MASK:    sel = max_evt;
            MINMAX_MASK: sel = min_evt | max_evt;
            default:     sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pwm_carrier_gen_clkdiv.sv
// Carrier prescaler: tick every clkdiv+1 cycles while enabled, every cycle when bypassed.
module pwm_clkdiv #(
    parameter int DIVCLK_WIDTH = pwm_carrier_gen_pkg::DIVCLK_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clkdiv_onoff,
    input  logic [DIVCLK_WIDTH-1:0] clkdiv,
    output logic                    tick
);
    import pwm_carrier_gen_pkg::*;

    logic [DIVCLK_WIDTH-1:0] r_cnt;
    logic                    w_div_run;

    // Tick decode; clkdiv is compared live so a new divide ratio applies at once.
    always_comb begin
        w_div_run = en && (clkdiv_onoff == CLKDIV_ON);
        tick      = 1'b0;
        if (!en) begin
            tick = 1'b0;
        end else if (!w_div_run) begin
            tick = 1'b1;
        end else begin
            tick = (r_cnt == clkdiv);
        end
    end

    // Prescaler counter, parked at zero whenever division is not active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_div_run) begin
            r_cnt <= '0;
        end else if (r_cnt == clkdiv) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_carrier_gen.sv
// Shared PWM carrier counter with shadowed configuration, min/max/update pulses
// and a decimated interrupt request.
module pwm_carrier_gen #(
    parameter int PWMCOUNT_WIDTH = pwm_carrier_gen_pkg::PWMCOUNT_WIDTH,
    parameter int DIVCLK_WIDTH   = pwm_carrier_gen_pkg::DIVCLK_WIDTH,
    parameter int EVTCOUNT_WIDTH = pwm_carrier_gen_pkg::EVTCOUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      carr_onoff,
    input  logic [1:0]                count_mode,
    input  logic [1:0]                mask_mode,
    input  logic                      clkdiv_onoff,
    input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [EVTCOUNT_WIDTH-1:0] evt_num,
    input  logic                      int_onoff,
    output logic [PWMCOUNT_WIDTH-1:0] carrier,
    output logic                      dir,
    output logic                      min_evt,
    output logic                      max_evt,
    output logic                      upd_evt,
    output logic                      irq
);
    import pwm_carrier_gen_pkg::*;

    logic [PWMCOUNT_WIDTH-1:0] r_carrier, r_period_sh;
    logic [EVTCOUNT_WIDTH-1:0] r_evtnum_sh, r_evt_cnt;
    count_mode_e               r_mode_sh, w_mode;
    mask_mode_e                r_mask_sh;
    logic                      r_dir, r_min_evt, r_max_evt, r_upd_evt, r_irq;

    logic                      w_on, w_load, w_tick, w_sel, w_count, w_dir_next;
    logic [PWMCOUNT_WIDTH-1:0] w_period, w_next, w_inc, w_dec;

    pwm_clkdiv #(.DIVCLK_WIDTH(DIVCLK_WIDTH)) u_clkdiv (
        .clk          (clk),
        .rst          (rst),
        .en           (w_on),
        .clkdiv_onoff (clkdiv_onoff),
        .clkdiv       (clkdiv),
        .tick         (w_tick)
    );

    // The reload cycle already counts with the freshly loaded period and mode.
    always_comb begin
        w_on     = (carr_onoff == CARR_ON);
        w_load   = !w_on || r_min_evt;
        w_period = w_load ? period : r_period_sh;
        w_mode   = w_load ? count_mode_e'(count_mode) : r_mode_sh;
        w_sel    = evt_selected(r_mask_sh, r_min_evt, r_max_evt);
    end

    // Next carrier value and direction for the active count mode.
    always_comb begin
        w_next     = r_carrier;
        w_dir_next = r_dir;
        w_count    = 1'b0;
        w_inc      = r_carrier + 1'b1;
        w_dec      = r_carrier - 1'b1;
        case (w_mode)
            COUNT_UP: begin
                w_count    = 1'b1;
                w_dir_next = 1'b0;
                if (r_carrier >= w_period) begin
                    w_next = '0;
                end else begin
                    w_next = w_inc;
                end
            end
            COUNT_DOWN: begin
                w_count    = 1'b1;
                w_dir_next = 1'b1;
                if ((r_carrier == '0) || (r_carrier > w_period)) begin
                    w_next = w_period;
                end else begin
                    w_next = w_dec;
                end
            end
            COUNT_UPDOWN: begin
                w_count = 1'b1;
                if (w_period == '0) begin
                    w_next     = '0;
                    w_dir_next = 1'b0;
                end else if ((r_carrier == '0) || (!r_dir && (r_carrier < w_period))) begin
                    w_next     = w_inc;
                    w_dir_next = (w_inc == w_period);
                end else begin
                    w_next     = w_dec;
                    w_dir_next = (w_dec != '0);
                end
            end
            default: begin
                w_count = 1'b0;
            end
        endcase
    end

    // Shadow configuration: tracks inputs while off, reloads on min_evt while running.
    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_period_sh <= period;
            r_mode_sh   <= count_mode_e'(count_mode);
            r_mask_sh   <= mask_mode_e'(mask_mode);
            r_evtnum_sh <= evt_num;
        end else begin
            r_period_sh <= r_period_sh;
            r_mode_sh   <= r_mode_sh;
            r_mask_sh   <= r_mask_sh;
            r_evtnum_sh <= r_evtnum_sh;
        end
    end

    // Carrier, direction and the min/max/update pulses.
    always_ff @(posedge clk) begin
        if (rst || !w_on) begin
            r_carrier <= '0;
            r_dir     <= 1'b0;
            r_min_evt <= 1'b0;
            r_max_evt <= 1'b0;
            r_upd_evt <= 1'b0;
        end else if (w_tick) begin
            r_carrier <= w_next;
            r_dir     <= w_dir_next;
            r_min_evt <= w_count && (w_next == '0);
            r_max_evt <= w_count && (w_next == w_period);
            r_upd_evt <= w_count && (w_next == '0);
        end else begin
            r_min_evt <= 1'b0;
            r_max_evt <= 1'b0;
            r_upd_evt <= 1'b0;
        end
    end

    // Event decimation; the counter keeps its phase even with the interrupt gated off.
    always_ff @(posedge clk) begin
        if (rst || !w_on) begin
            r_evt_cnt <= '0;
            r_irq     <= 1'b0;
        end else if (w_sel) begin
            if (r_evt_cnt == r_evtnum_sh) begin
                r_evt_cnt <= '0;
                r_irq     <= (int_onoff == INT_ON);
            end else begin
                r_evt_cnt <= r_evt_cnt + 1'b1;
                r_irq     <= 1'b0;
            end
        end else begin
            r_irq <= 1'b0;
        end
    end

    assign carrier = r_carrier;
    assign dir     = r_dir;
    assign min_evt = r_min_evt;
    assign max_evt = r_max_evt;
    assign upd_evt = r_upd_evt;
    assign irq     = r_irq;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Scoreboard bench: a phase-based carrier model pushes expected outputs per clock,
// an independent monitor pops and compares them against the DUT.
module tb_pwm_carrier_gen;
    import pwm_carrier_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst, carr_onoff, clkdiv_onoff, int_onoff;
    logic [1:0]  count_mode, mask_mode;
    logic [3:0]  clkdiv;
    logic [15:0] period;
    logic [2:0]  evt_num;
    logic [15:0] carrier;
    logic        dir, min_evt, max_evt, upd_evt, irq;

    always #5 clk = ~clk;

    pwm_carrier_gen dut (
        .clk(clk), .rst(rst), .carr_onoff(carr_onoff), .count_mode(count_mode),
        .mask_mode(mask_mode), .clkdiv_onoff(clkdiv_onoff), .clkdiv(clkdiv),
        .period(period), .evt_num(evt_num), .int_onoff(int_onoff),
        .carrier(carrier), .dir(dir), .min_evt(min_evt), .max_evt(max_evt),
        .upd_evt(upd_evt), .irq(irq)
    );

    typedef struct {
        int carrier;
        bit dir;
        bit mn;
        bit mx;
        bit upd;
        bit irq;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: position within the carrier period, not the counter itself.
    int m_k = 0, m_pc = 0, m_ev = 0;
    int sh_p = 0, sh_mode = 0, sh_mask = 0, sh_evn = 0;

    function automatic int period_len(input int m, input int p);
        case (m)
            COUNT_UP, COUNT_DOWN: return p + 1;
            COUNT_UPDOWN:         return (p == 0) ? 1 : 2 * p;
            default:              return 1;
        endcase
    endfunction

    function automatic int carrier_at(input int m, input int p, input int k);
        case (m)
            COUNT_UP:     return k;
            COUNT_DOWN:   return (k == 0) ? 0 : p + 1 - k;
            COUNT_UPDOWN: return (k <= p) ? k : 2 * p - k;
            default:      return 0;
        endcase
    endfunction

    task automatic model_step();
        int pe, me;
        bit load, sel, tk;
        if (rst) begin
            m_k = 0; m_pc = 0; m_ev = 0;
            e.carrier = 0; e.dir = 0; e.mn = 0; e.mx = 0; e.upd = 0; e.irq = 0;
            sh_p = period; sh_mode = count_mode; sh_mask = mask_mode; sh_evn = evt_num;
        end else begin
            load = (carr_onoff == CARR_OFF) || e.mn;
            sel  = (e.mn && (sh_mask == MIN_MASK || sh_mask == MINMAX_MASK)) ||
                   (e.mx && (sh_mask == MAX_MASK || sh_mask == MINMAX_MASK));
            pe = load ? int'(period) : sh_p;
            me = load ? int'(count_mode) : sh_mode;
            if (carr_onoff == CARR_OFF) begin
                m_k = 0; m_pc = 0; m_ev = 0;
                e.carrier = 0; e.dir = 0; e.mn = 0; e.mx = 0; e.upd = 0; e.irq = 0;
            end else begin
                tk   = (clkdiv_onoff == CLKDIV_OFF) || (m_pc == int'(clkdiv));
                m_pc = (tk || clkdiv_onoff == CLKDIV_OFF) ? 0 : (m_pc + 1) % 16;
                e.mn = 0; e.mx = 0; e.upd = 0;
                if (tk && me != NO_COUNT) begin
                    m_k       = (m_k + 1) % period_len(me, pe);
                    e.carrier = carrier_at(me, pe, m_k);
                    if (me == COUNT_DOWN)        e.dir = 1'b1;
                    else if (me == COUNT_UPDOWN) e.dir = (pe > 0) && (m_k >= pe);
                    else                         e.dir = 1'b0;
                    e.mn  = (e.carrier == 0);
                    e.mx  = (e.carrier == pe);
                    e.upd = e.mn;
                end
                e.irq = 1'b0;
                if (sel) begin
                    if (m_ev == sh_evn) begin
                        m_ev  = 0;
                        e.irq = (int_onoff == INT_ON);
                    end else begin
                        m_ev = (m_ev + 1) % 8;
                    end
                end
            end
            if (load) begin
                sh_p = period; sh_mode = count_mode; sh_mask = mask_mode; sh_evn = evt_num;
            end
        end
        q.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cfg(input logic [1:0] cm, input logic [15:0] p, input logic cdo,
                       input logic [3:0] cd, input logic [1:0] mm, input logic [2:0] en,
                       input logic io);
        count_mode = cm; period = p; clkdiv_onoff = cdo; clkdiv = cd;
        mask_mode = mm; evt_num = en; int_onoff = io;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Monitor: outputs are presented every clock; compare each against the queued prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("carrier", int'(carrier), x.carrier);
                chk("dir", int'(dir), int'(x.dir));
                chk("min_evt", int'(min_evt), int'(x.mn));
                chk("max_evt", int'(max_evt), int'(x.mx));
                chk("upd_evt", int'(upd_evt), int'(x.upd));
                chk("irq", int'(irq), int'(x.irq));
            end
        end
    end

    initial begin
        int len;
        rst = 1'b1;
        carr_onoff = CARR_OFF;
        cfg(COUNT_UP, 16'd4, CLKDIV_OFF, 4'd0, MIN_MASK, 3'd0, INT_ON);
        run(2);
        rst = 1'b0;
        run(2);
        carr_onoff = CARR_ON;
        run(20);

        carr_onoff = CARR_OFF;
        cfg(COUNT_UPDOWN, 16'd3, CLKDIV_ON, 4'd1, MINMAX_MASK, 3'd1, INT_ON);
        run(2);
        carr_onoff = CARR_ON;
        run(30);

        carr_onoff = CARR_OFF;
        cfg(COUNT_DOWN, 16'd5, CLKDIV_OFF, 4'd0, MAX_MASK, 3'd0, INT_ON);
        run(2);
        carr_onoff = CARR_ON;
        run(9);
        period = 16'd2;
        run(20);

        carr_onoff = CARR_OFF;
        cfg(COUNT_UP, 16'd1, CLKDIV_OFF, 4'd0, MINMAX_MASK, 3'd2, INT_ON);
        run(2);
        carr_onoff = CARR_ON;
        run(20);
        int_onoff = INT_OFF;
        run(10);
        int_onoff = INT_ON;
        run(10);

        carr_onoff = CARR_OFF;
        cfg(COUNT_UP, 16'd0, CLKDIV_OFF, 4'd0, MINMAX_MASK, 3'd0, INT_ON);
        run(2);
        carr_onoff = CARR_ON;
        run(10);
        count_mode = NO_COUNT;
        run(10);

        carr_onoff = CARR_OFF;
        cfg(COUNT_UP, 16'd6, CLKDIV_OFF, 4'd0, MIN_MASK, 3'd0, INT_ON);
        run(2);
        carr_onoff = CARR_ON;
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(5);
        carr_onoff = CARR_OFF;
        period = 16'd9;
        run(3);
        count_mode = COUNT_DOWN;
        run(3);
        carr_onoff = CARR_ON;
        run(15);

        for (int s = 0; s < 40; s++) begin
            carr_onoff   = CARR_OFF;
            period       = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
            count_mode   = 2'($urandom_range(0, 3));
            mask_mode    = 2'($urandom_range(0, 3));
            evt_num      = 3'($urandom_range(0, 7));
            int_onoff    = 1'($urandom_range(0, 1));
            clkdiv_onoff = 1'($urandom_range(0, 1));
            clkdiv       = 4'($urandom_range(0, 3));
            run($urandom_range(1, 2));
            carr_onoff = CARR_ON;
            len = $urandom_range(10, 60);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) period = 16'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) count_mode = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) mask_mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) evt_num = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) int_onoff = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 31) == 0) clkdiv = 4'($urandom_range(0, 3));
                rst = ($urandom_range(0, 99) == 0);
                step();
            end
            rst = 1'b0;
        end

        run(2);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
